// File: rtl/anubis_round_seq.sv
// rtl/anubis_round_seq.sv - Anubis round sequencer for N=4..10 key words and S cycles per stage.
// Define ANUBIS_DEC_EN to build the round-key buffer and decrypt key pass.
module anubis_round_seq #(
   parameter int KEY_WORDS    = 4,
   parameter int STAGE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_dec,
   input  logic [127:0]            in_text,
   input  logic [32*KEY_WORDS-1:0] in_key,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [127:0]            out_text,
   output logic                    busy,
   output logic [4:0]              round_idx,
   output logic                    kev_go,
   output logic [32*KEY_WORDS-1:0] kev_key_o,
   input  logic [32*KEY_WORDS-1:0] kev_key_i,
   output logic                    ksel_go,
   output logic                    ksel_dec,
   input  logic [127:0]            ksel_rk_i,
   output logic                    rnd_go,
   output logic [1:0]              rnd_type,
   output logic [127:0]            rnd_state_o,
   output logic [127:0]            rnd_rk_o,
   input  logic [127:0]            rnd_state_i
);
   localparam int R  = 8 + KEY_WORDS;
   localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
   localparam logic [4:0]    R_IDX    = 5'(R);
   localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, EVOLVE, SELECT, ROUND, DONE} state_t;

   state_t                  state, state_nx;
   logic [CW-1:0]           cnt;
   logic [4:0]              r;
   logic [127:0]            text_q;
   logic [127:0]            rk_q;
   logic [32*KEY_WORDS-1:0] key_q;
   logic                    dec_q;
   logic                    kpass_q;
   logic                    dec_in;
   logic                    accept;
   logic                    stage_end;
   logic                    last_round;
   logic [127:0]            rk_buf_rd;

   assign accept     = (state == IDLE) && in_valid;
   assign stage_end  = (cnt == CNT_LAST);
   assign last_round = (r == R_IDX);

`ifdef ANUBIS_DEC_EN
   localparam int IW = $clog2(R + 1);
   logic [127:0] rk_buf [0:R];

   assign dec_in   = in_dec;
   assign ksel_dec = dec_q;

   always_ff @(posedge clk) begin
      if (state == SELECT && stage_end && kpass_q)
         rk_buf[IW'(r)] <= ksel_rk_i;
   end

   // Round pass walks the buffer backwards: round r+1 needs the key selected at R-(r+1).
   assign rk_buf_rd = rk_buf[IW'(R_IDX - 5'd1 - r)];
`else
   // Without the key buffer every request is an encryption.
   assign dec_in    = 1'b0 & in_dec;
   assign ksel_dec  = 1'b0;
   assign rk_buf_rd = '0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid) state_nx = LOAD;
         LOAD:    state_nx = SELECT;
         SELECT:  if (stage_end) state_nx = (kpass_q && !last_round) ? EVOLVE : ROUND;
         EVOLVE:  if (stage_end) state_nx = SELECT;
         ROUND:   if (stage_end) state_nx = last_round ? DONE : (dec_q ? ROUND : EVOLVE);
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         r       <= '0;
         text_q  <= '0;
         rk_q    <= '0;
         key_q   <= '0;
         dec_q   <= 1'b0;
         kpass_q <= 1'b0;
      end else begin
         state <= state_nx;

         if (state == EVOLVE || state == SELECT || state == ROUND)
            cnt <= stage_end ? '0 : cnt + 1'b1;
         else
            cnt <= '0;

         if (accept) begin
            text_q  <= in_text;
            key_q   <= in_key;
            dec_q   <= dec_in;
            kpass_q <= dec_in;
            r       <= '0;
         end

         if (state == EVOLVE && stage_end)
            key_q <= kev_key_i;

         if (state == SELECT && stage_end) begin
            rk_q <= ksel_rk_i;
            // Key pass advances r here; the round pass restarts from r=0.
            if (kpass_q) begin
               if (last_round) begin
                  r       <= '0;
                  kpass_q <= 1'b0;
               end else begin
                  r <= r + 5'd1;
               end
            end
         end

         if (state == ROUND && stage_end) begin
            text_q <= rnd_state_i;
            if (!last_round) begin
               r <= r + 5'd1;
               if (dec_q)
                  rk_q <= rk_buf_rd;
            end
         end

         if (state == DONE && out_ready)
            r <= '0;
      end
   end

   assign in_ready    = (state == IDLE);
   assign busy        = (state != IDLE);
   assign out_valid   = (state == DONE);
   assign out_text    = (state == DONE) ? text_q : '0;
   assign round_idx   = r;
   assign kev_go      = (state == EVOLVE) && (cnt == '0);
   assign ksel_go     = (state == SELECT) && (cnt == '0);
   assign rnd_go      = (state == ROUND) && (cnt == '0);
   assign rnd_type    = (r == 5'd0) ? 2'd0 : (last_round ? 2'd2 : 2'd1);
   assign kev_key_o   = key_q;
   assign rnd_state_o = text_q;
   assign rnd_rk_o    = rk_q;
endmodule

// File: doc/anubis_round_seq.md
Name: anubis_round_seq

Overview:
- Parametrised control and sequencing core for the Anubis cipher. Supports the full key-size range N = 4..10 (128..320-bit keys), with R = 8+N rounds.
- Owns the state register, key register and round counter. Drives external key-evolution, key-selection and round-function units with go strobes and captures their results after a programmable number of cycles per stage.
- Uses valid/ready handshakes on both input and output.
- Replaces the fixed 128-bit, fixed-timing top-level controller.

Parameters:
- KEY_WORDS, 4, N: key length in 32-bit words; legal range 4..10.
- STAGE_CYCLES, 4, S: cycles per stage (evolve/select/round); must be ≥1. Result is captured on the last cycle of the stage.
- ROUNDS, 8+KEY_WORDS, localparam R; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_dec  in  1  1 = decrypt; latched on accept
- in_text  in  128  plaintext/ciphertext
- in_key  in  32*KEY_WORDS  cipher key
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_text  out  128  result; stable while out_valid
- busy  out  1  high in any state other than IDLE
- round_idx  out  5  current round r, 0..R
- kev_go  out  1  1-cycle pulse on first EVOLVE cycle
- kev_key_o  out  32*KEY_WORDS  key register to evolution unit
- kev_key_i  in  32*KEY_WORDS  evolved key
- ksel_go  out  1  1-cycle pulse on first SELECT cycle
- ksel_dec  out  1  latched mode; tells selector to apply theta
- ksel_rk_i  in  128  selected round key
- rnd_go  out  1  1-cycle pulse on first ROUND cycle
- rnd_type  out  2  0 = key addition only, 1 = full round, 2 = final round
- rnd_state_o  out  128  state register
- rnd_rk_o  out  128  round key for current round
- rnd_state_i  in  128  round result

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - State → IDLE.
  - in_ready=1 from the first cycle after reset deasserts.
  - out_valid, busy, all go strobes = 0.
  - round_idx, out_text = 0; state/key/round-key registers cleared.
  - Reset mid-operation aborts at once and discards all data.
- FSM states: IDLE, LOAD, EVOLVE, SELECT, ROUND, DONE.
- Stage counter: 0..S-1; a stage exits when counter = S-1. Go strobes fire when counter = 0.
- Transitions (encrypt):
  - IDLE: in_valid & in_ready → LOAD. Latches text, key and in_dec.
  - LOAD: 1 cycle; r=0 → SELECT.
  - SELECT: captures ksel_rk_i into round-key register → ROUND.
  - ROUND: captures rnd_state_i; rnd_type is 0 at r=0, 1 for 0<r<R, 2 at r=R.
    - r<R: r+1 → EVOLVE.
    - r=R: → DONE.
  - EVOLVE: captures kev_key_i into key register → SELECT.
- Completion and output handshake:
  - DONE: out_valid=1, out_text = state register.
  - out_valid & out_ready → IDLE; in_ready rises on the next cycle.
  - out_ready held low → DONE is held indefinitely with out_text stable.
- in_valid outside IDLE is ignored and is never queued.
- Latency, accept edge to out_valid high: 2 + S*(3R+2). For N=4, S=4: 154 cycles.
- rnd_rk_o, rnd_state_o and kev_key_o are registered; they are stable for the whole stage.
- round_idx never exceeds R; counters do not wrap.

Optional Feature:
- Macro: ANUBIS_DEC_EN
- Defined:
  - Adds a round-key buffer of R+1 entries × 128 bits.
  - Decrypt accept runs a key pass first: SELECT at r=0, then EVOLVE+SELECT for r=1..R, writing entry r. ksel_dec=1 during this pass.
  - It then runs a ROUND pass for r=0..R, reading entry R-r. rnd_type is assigned as in encrypt mode.
  - Latency is identical to encrypt.
  - Encrypt mode behaves exactly as when the macro is undefined.
- Undefined:
  - No buffer is built; in_dec is ignored and ksel_dec is tied to 0.
  - Every request is encrypted.

Test Plan:
- Reset then single encrypt, N=4, S=4, text=0, key=0, with a model datapath:
  - out_valid rises exactly 154 cycles after accept; out_text matches the golden vector.
  - Exactly 12 kev_go, 13 ksel_go and 13 rnd_go pulses.
- N=10, S=1: out_valid at 2+1*(3*18+2)=58 cycles; round_idx sequence 0..18; rnd_type 0, then 1 ×17, then 2.
- out_ready held low 20 cycles in DONE:
  - out_valid and out_text stable; in_ready=0.
  - On release, IDLE next cycle; a back-to-back in_valid is accepted one cycle later.
- in_valid pulsed mid-operation: not accepted; the result is unchanged.
- reset asserted in ROUND at r=5:
  - Next cycle: IDLE, busy=0, out_valid=0, round_idx=0.
  - A fresh request completes correctly.
- ANUBIS_DEC_EN:
  - Encrypt-then-decrypt round trip across 100 random text/key pairs returns the original plaintext.
  - rnd_rk_o at ROUND r equals the key captured at SELECT R-r.
